operand_fetch: RTL and testbench

- Register-read stage between instruction fetch and execute.
- Accepts one instruction per handshake and drives the register_file read addresses (addr_rs0/addr_rs1) from the instruction fields.
- Captures the two source operands, with bypass from the concurrent register_file write port, into a single-entry output register.
- Keeps held operands coherent with writebacks while execute is stalled.

---
 rtl/operand_fetch.sv | 120 ++++++++++++
 tb/tb_operand_fetch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Register-read stage: captures two source operands (with writeback bypass)
// into a single-entry output register and keeps them coherent while stalled.
module operand_fetch #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [REG_AW-1:0] rf_addr_rs0,
    output logic [REG_AW-1:0] rf_addr_rs1,
    input  logic [XLEN-1:0]   rf_data_rs0,
    input  logic [XLEN-1:0]   rf_data_rs1,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr_rd2,
    input  logic [XLEN-1:0]   wb_data_rd2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_instr,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_rs0_val,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [REG_AW-1:0] out_rd
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic              accept;
    logic              consume;
    logic              hold_update;
    logic [REG_AW-1:0] held_rs0;
    logic [REG_AW-1:0] held_rs1;
    logic              wb_hit_rs0;
    logic              wb_hit_rs1;

    assign rf_addr_rs0 = in_instr[15 +: REG_AW];
    assign rf_addr_rs1 = in_instr[20 +: REG_AW];

    assign held_rs0 = out_instr[15 +: REG_AW];
    assign held_rs1 = out_instr[20 +: REG_AW];

    assign out_valid = (state == FULL);

    // x0 always reads zero; a same-edge write to the source wins over the stale read
    function automatic logic [XLEN-1:0] pick_operand(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   rf_val
    );
        if (addr == '0)
            return '0;
        else if (wb_we && (wb_addr_rd2 == addr))
            return wb_data_rd2;
        else
            return rf_val;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= EMPTY;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b1;
        accept     = 1'b0;
        consume    = 1'b0;
        case (state)
            EMPTY: in_ready = 1'b1;
            FULL:  in_ready = out_ready;
            default: in_ready = 1'b1;
        endcase
        accept  = in_valid && in_ready && !flush;
        consume = out_valid && out_ready;
        if (flush)
            next_state = EMPTY;
        else if (accept)
            next_state = FULL;
        else if (consume)
            next_state = EMPTY;
    end

    // A stalled entry tracks writebacks; a consumed or flushed entry is frozen
    assign hold_update = (state == FULL) && !consume && !flush;
    assign wb_hit_rs0  = hold_update && wb_we && (wb_addr_rd2 != '0) && (wb_addr_rd2 == held_rs0);
    assign wb_hit_rs1  = hold_update && wb_we && (wb_addr_rd2 != '0) && (wb_addr_rd2 == held_rs1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_instr   <= '0;
            out_pc      <= '0;
            out_rs0_val <= '0;
            out_rs1_val <= '0;
            out_rd      <= '0;
        end else if (accept) begin
            out_instr   <= in_instr;
            out_pc      <= in_pc;
            out_rs0_val <= pick_operand(rf_addr_rs0, rf_data_rs0);
            out_rs1_val <= pick_operand(rf_addr_rs1, rf_data_rs1);
            out_rd      <= in_instr[7 +: REG_AW];
        end else begin
            if (wb_hit_rs0)
                out_rs0_val <= wb_data_rd2;
            if (wb_hit_rs1)
                out_rs1_val <= wb_data_rd2;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch with a hand-driven register file.
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_addr_rs0;
    logic [4:0]  rf_addr_rs1;
    logic [31:0] rf_data_rs0;
    logic [31:0] rf_data_rs1;
    logic        wb_we;
    logic [4:0]  wb_addr_rd2;
    logic [31:0] wb_data_rd2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_rs0_val;
    logic [31:0] out_rs1_val;
    logic [4:0]  out_rd;

    logic [31:0] rf [32];

    int tests_run;
    int tests_failed;

    localparam logic [31:0] I_ADD_5_5_6 = 32'h006282B3;
    localparam logic [31:0] I_ADD_7_5_6 = 32'h006283B3;
    localparam logic [31:0] I_ADD_8_0_6 = 32'h00600433;

    operand_fetch #(.XLEN(32), .REG_AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .rf_addr_rs0 (rf_addr_rs0),
        .rf_addr_rs1 (rf_addr_rs1),
        .rf_data_rs0 (rf_data_rs0),
        .rf_data_rs1 (rf_data_rs1),
        .wb_we       (wb_we),
        .wb_addr_rd2 (wb_addr_rd2),
        .wb_data_rd2 (wb_data_rd2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_rs0_val (out_rs0_val),
        .out_rs1_val (out_rs1_val),
        .out_rd      (out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_data_rs0 = rf[rf_addr_rs0];
    assign rf_data_rs1 = rf[rf_addr_rs1];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic applyWrite(input logic we, input logic [4:0] addr, input logic [31:0] data);
        wb_we       = we;
        wb_addr_rd2 = addr;
        wb_data_rd2 = data;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[5] = 32'h11111111;
        rf[6] = 32'h22222222;
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        applyWrite(1'b0, 5'd0, 32'h0);

        #12;
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("reset_out_instr", out_instr, 32'h0);
        checkOutput("reset_out_pc", out_pc, 32'h0);
        checkOutput("reset_rs0", out_rs0_val, 32'h0);
        checkOutput("reset_rs1", out_rs1_val, 32'h0);
        checkOutput("reset_rd", {27'b0, out_rd}, 32'h0);
        rst = 1'b1;
        cycle();
        checkOutput("idle_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("idle_in_ready", {31'b0, in_ready}, 32'h1);

        // Basic capture and register-file addresses
        applyStimulus(1'b1, I_ADD_5_5_6, 32'h100, 1'b1, 1'b0);
        #1;
        checkOutput("rf_addr_rs0", {27'b0, rf_addr_rs0}, 32'd5);
        checkOutput("rf_addr_rs1", {27'b0, rf_addr_rs1}, 32'd6);
        cycle();
        checkOutput("add_out_valid", {31'b0, out_valid}, 32'h1);
        checkOutput("add_rs0", out_rs0_val, 32'h11111111);
        checkOutput("add_rs1", out_rs1_val, 32'h22222222);
        checkOutput("add_rd", {27'b0, out_rd}, 32'd5);
        checkOutput("add_pc", out_pc, 32'h100);
        checkOutput("add_instr", out_instr, I_ADD_5_5_6);

        // Back-to-back: second instruction one cycle later
        applyStimulus(1'b1, I_ADD_7_5_6, 32'h104, 1'b1, 1'b0);
        cycle();
        checkOutput("b2b_out_valid", {31'b0, out_valid}, 32'h1);
        checkOutput("b2b_pc", out_pc, 32'h104);
        checkOutput("b2b_rd", {27'b0, out_rd}, 32'd7);
        applyStimulus(1'b0, I_ADD_7_5_6, 32'h104, 1'b1, 1'b0);
        cycle();
        checkOutput("drain_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("drain_pc_kept", out_pc, 32'h104);

        // Bypass from same-edge writeback to x6
        applyStimulus(1'b1, I_ADD_5_5_6, 32'h108, 1'b1, 1'b0);
        applyWrite(1'b1, 5'd6, 32'hDEADBEEF);
        cycle();
        rf[6] = 32'hDEADBEEF;
        applyWrite(1'b0, 5'd0, 32'h0);
        checkOutput("bypass_rs1", out_rs1_val, 32'hDEADBEEF);
        checkOutput("bypass_rs0", out_rs0_val, 32'h11111111);

        // Stall three cycles; writeback to x5 in the second updates the held operand
        applyStimulus(1'b1, I_ADD_7_5_6, 32'h200, 1'b0, 1'b0);
        #1;
        checkOutput("stall_in_ready0", {31'b0, in_ready}, 32'h0);
        cycle();
        checkOutput("stall_pc1", out_pc, 32'h108);
        checkOutput("stall_in_ready1", {31'b0, in_ready}, 32'h0);
        applyWrite(1'b1, 5'd5, 32'hCAFEF00D);
        cycle();
        rf[5] = 32'hCAFEF00D;
        applyWrite(1'b0, 5'd0, 32'h0);
        checkOutput("stall_rs0_upd", out_rs0_val, 32'hCAFEF00D);
        checkOutput("stall_instr2", out_instr, I_ADD_5_5_6);
        checkOutput("stall_in_ready2", {31'b0, in_ready}, 32'h0);
        cycle();
        checkOutput("stall_rs1_kept", out_rs1_val, 32'hDEADBEEF);
        checkOutput("stall_rd3", {27'b0, out_rd}, 32'd5);
        checkOutput("stall_valid3", {31'b0, out_valid}, 32'h1);

        // rs1=x0 alongside a write to x0: operand stays zero, held or loaded
        applyStimulus(1'b1, I_ADD_8_0_6, 32'h300, 1'b1, 1'b0);
        applyWrite(1'b1, 5'd0, 32'hFFFFFFFF);
        cycle();
        checkOutput("x0_rs0", out_rs0_val, 32'h0);
        checkOutput("x0_rs1", out_rs1_val, 32'hDEADBEEF);
        checkOutput("x0_rd", {27'b0, out_rd}, 32'd8);
        applyStimulus(1'b0, I_ADD_8_0_6, 32'h300, 1'b0, 1'b0);
        cycle();
        applyWrite(1'b0, 5'd0, 32'h0);
        checkOutput("x0_held_rs0", out_rs0_val, 32'h0);

        // Flush while FULL drops both held entry and incoming instruction
        applyStimulus(1'b1, I_ADD_7_5_6, 32'h400, 1'b1, 1'b1);
        #1;
        checkOutput("flush_in_ready", {31'b0, in_ready}, 32'h1);
        cycle();
        checkOutput("flush_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("flush_pc_kept", out_pc, 32'h300);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle();
        checkOutput("flush_after_valid", {31'b0, out_valid}, 32'h0);

        // Asynchronous reset mid-cycle while FULL
        applyStimulus(1'b1, I_ADD_5_5_6, 32'h500, 1'b1, 1'b0);
        cycle();
        checkOutput("pre_rst_valid", {31'b0, out_valid}, 32'h1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("async_rst_pc", out_pc, 32'h0);
        checkOutput("async_rst_rs0", out_rs0_val, 32'h0);
        #1;
        rst = 1'b1;
        cycle();
        checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
